// File: rtl/vga_ports_pkg.sv
// Shared constants for the VGA/CGA I/O port front end.
// Port numbers, CRTC register indices, palette component expansion.
// No timing or flow control of its own.
package vga_ports_pkg;

  localparam logic [15:0] PORT_DAC_RIDX = 16'h03C7;
  localparam logic [15:0] PORT_DAC_WIDX = 16'h03C8;
  localparam logic [15:0] PORT_DAC_DATA = 16'h03C9;
  localparam logic [15:0] PORT_CRTC_IDX = 16'h03D4;
  localparam logic [15:0] PORT_CRTC_DAT = 16'h03D5;
  localparam logic [15:0] PORT_MODE     = 16'h03D8;
  localparam logic [15:0] PORT_STATUS   = 16'h03DA;

  localparam logic [7:0] CRTC_CUR_START = 8'h0A;
  localparam logic [7:0] CRTC_CUR_END   = 8'h0B;
  localparam logic [7:0] CRTC_CUR_HI    = 8'h0E;
  localparam logic [7:0] CRTC_CUR_LO    = 8'h0F;

  // Stretch a 6-bit DAC component to 8 bits by replicating its top bits
  // so that full scale maps to 8'hFF.
  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/dac_sequencer.sv
// Palette DAC sequencer: R/G/B write triples to palette RAM, fetches for R/G/B reads.
// Latency: dac_we one cycle after the third write; fetch lands in the latch 3 edges after start.
// No backpressure: the CPU bus spaces strobes; a fetch colliding with dac_we is retried.
module dac_sequencer
  import vga_ports_pkg::*;
(
  input  logic        clock_25,
  input  logic        reset_n,
  input  logic        set_widx,
  input  logic        set_ridx,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [7:0]  wdat,
  input  logic [31:0] dac_rdata,
  output logic [7:0]  widx,
  output logic [7:0]  rd_comp,
  output logic [7:0]  dac_address,
  output logic        dac_we,
  output logic [31:0] dac_wdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ADDR    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RETRY   = 2'd3;

  logic [1:0]  wphase;
  logic [1:0]  rphase;
  logic [7:0]  ridx;
  logic [7:0]  ridx_next;
  logic [5:0]  r_lat;
  logic [5:0]  g_lat;
  logic [23:0] rd_lat;
  logic [1:0]  fetch_state;
  logic [7:0]  comp;
  logic        commit;
  logic        last_rd;
  logic        fetch_start;
  logic        unused_rdata_hi;

  assign commit      = data_wr && (wphase == 2'd2);
  assign last_rd     = data_rd && (rphase == 2'd2);
  assign fetch_start = set_ridx || last_rd;
  assign unused_rdata_hi = ^dac_rdata[31:24];

  // Read index after this cycle: reloaded by 3C7, bumped after the B read.
  always_comb begin
    ridx_next = ridx;
    if (set_ridx)
      ridx_next = wdat;
    else if (last_rd)
      ridx_next = ridx + 8'd1;
  end

  // Pick the fetched component for the current read phase, scaled back to 6 bits.
  always_comb begin
    comp = rd_lat[7:0];
    case (rphase)
      2'd0:    comp = rd_lat[23:16];
      2'd1:    comp = rd_lat[15:8];
      default: comp = rd_lat[7:0];
    endcase
    rd_comp = {2'b00, comp[7:2]};
  end

  // Write side: collect R and G, emit the full entry on B, advance the index.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      widx      <= 8'd0;
      wphase    <= 2'd0;
      r_lat     <= 6'd0;
      g_lat     <= 6'd0;
      dac_we    <= 1'b0;
      dac_wdata <= 32'd0;
    end else begin
      dac_we <= commit;
      if (set_widx) begin
        widx   <= wdat;
        wphase <= 2'd0;
      end else if (data_wr) begin
        case (wphase)
          2'd0: begin
            r_lat  <= wdat[5:0];
            wphase <= 2'd1;
          end
          2'd1: begin
            g_lat  <= wdat[5:0];
            wphase <= 2'd2;
          end
          default: begin
            dac_wdata <= {8'h00, expand6(r_lat), expand6(g_lat), expand6(wdat[5:0])};
            widx      <= widx + 8'd1;
            wphase    <= 2'd0;
          end
        endcase
      end
    end
  end

  // Port-B address: the write slot owns it during dac_we, otherwise it tracks ridx.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n)
      dac_address <= 8'd0;
    else
      dac_address <= commit ? widx : ridx_next;
  end

  // Read side: index and phase bookkeeping for R/G/B reads.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      ridx   <= 8'd0;
      rphase <= 2'd0;
    end else begin
      ridx <= ridx_next;
      if (set_ridx)
        rphase <= 2'd0;
      else if (data_rd)
        rphase <= last_rd ? 2'd0 : rphase + 2'd1;
    end
  end

  // Fetch FSM: present ridx, capture RAM data a cycle later; back off if a write owns the port.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      fetch_state <= S_IDLE;
      rd_lat      <= 24'd0;
    end else if (fetch_start) begin
      fetch_state <= S_ADDR;
    end else begin
      case (fetch_state)
        S_ADDR:    fetch_state <= dac_we ? S_RETRY : S_CAPTURE;
        S_CAPTURE: begin
          rd_lat      <= dac_rdata[23:0];
          fetch_state <= S_IDLE;
        end
        S_RETRY:   fetch_state <= S_ADDR;
        default:   fetch_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_ports.sv
// CGA/VGA I/O port front end: CRTC cursor/mode registers, status, palette DAC access.
// Latency: register writes visible next edge; io_data_out registered one cycle after io_read.
// No backpressure: strobes are accepted every cycle; the bus guarantees spacing for fetches.
module vga_ports
  import vga_ports_pkg::*;
#(
  parameter logic [5:0] CURSOR_LO_RST = 6'd14,
  parameter logic [4:0] CURSOR_HI_RST = 5'd15
) (
  input  logic        clock_25,
  input  logic        reset_n,
  input  logic [15:0] io_address,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [7:0]  io_data_in,
  output logic [7:0]  io_data_out,
  input  logic        vretrace,
  input  logic        display_off,
  output logic [10:0] cursor,
  output logic [5:0]  cursor_shape_lo,
  output logic [4:0]  cursor_shape_hi,
  output logic [1:0]  videomode,
  output logic [7:0]  dac_address,
  output logic        dac_we,
  output logic [31:0] dac_wdata,
  input  logic [31:0] dac_rdata
);

  logic [7:0] crtc_index;
  logic [7:0] crtc_rd;
  logic [7:0] rd_mux;
  logic [7:0] widx;
  logic [7:0] dac_comp;
  logic       rd_only;

  // A read coinciding with a write is dropped entirely, including DAC side effects.
  assign rd_only = io_read && !io_write;

  dac_sequencer u_dac (
    .clock_25    (clock_25),
    .reset_n     (reset_n),
    .set_widx    (io_write && (io_address == PORT_DAC_WIDX)),
    .set_ridx    (io_write && (io_address == PORT_DAC_RIDX)),
    .data_wr     (io_write && (io_address == PORT_DAC_DATA)),
    .data_rd     (rd_only && (io_address == PORT_DAC_DATA)),
    .wdat        (io_data_in),
    .dac_rdata   (dac_rdata),
    .widx        (widx),
    .rd_comp     (dac_comp),
    .dac_address (dac_address),
    .dac_we      (dac_we),
    .dac_wdata   (dac_wdata)
  );

  // CRTC index, cursor registers and video mode, written by OUT cycles.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      crtc_index      <= 8'd0;
      cursor          <= 11'd0;
      cursor_shape_lo <= CURSOR_LO_RST;
      cursor_shape_hi <= CURSOR_HI_RST;
      videomode       <= 2'd0;
    end else if (io_write) begin
      case (io_address)
        PORT_CRTC_IDX: crtc_index <= io_data_in;
        PORT_CRTC_DAT: begin
          case (crtc_index)
            CRTC_CUR_START: cursor_shape_lo <= io_data_in[5:0];
            CRTC_CUR_END:   cursor_shape_hi <= io_data_in[4:0];
            CRTC_CUR_HI:    cursor[10:8]    <= io_data_in[2:0];
            CRTC_CUR_LO:    cursor[7:0]     <= io_data_in;
            default: ;
          endcase
        end
        PORT_MODE: videomode <= io_data_in[1:0];
        default: ;
      endcase
    end
  end

  // CRTC data readback at the current index; undefined indices read as zero.
  always_comb begin
    crtc_rd = 8'h00;
    case (crtc_index)
      CRTC_CUR_START: crtc_rd = {2'b00, cursor_shape_lo};
      CRTC_CUR_END:   crtc_rd = {3'b000, cursor_shape_hi};
      CRTC_CUR_HI:    crtc_rd = {5'b00000, cursor[10:8]};
      CRTC_CUR_LO:    crtc_rd = cursor[7:0];
      default:        crtc_rd = 8'h00;
    endcase
  end

  // Port read multiplexer; undecoded ports float high.
  always_comb begin
    rd_mux = 8'hFF;
    case (io_address)
      PORT_CRTC_IDX: rd_mux = crtc_index;
      PORT_CRTC_DAT: rd_mux = crtc_rd;
      PORT_MODE:     rd_mux = {6'b000000, videomode};
      PORT_STATUS:   rd_mux = {4'b0000, vretrace, 2'b00, display_off};
      PORT_DAC_WIDX: rd_mux = widx;
      PORT_DAC_RIDX: rd_mux = 8'h03;
      PORT_DAC_DATA: rd_mux = dac_comp;
      default:       rd_mux = 8'hFF;
    endcase
  end

  // Registered read data, held until the next read; a write+read cycle returns FF.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n)
      io_data_out <= 8'hFF;
    else if (io_read && io_write)
      io_data_out <= 8'hFF;
    else if (io_read)
      io_data_out <= rd_mux;
  end

endmodule

// File: tb/tb_vga_ports.sv
// Bench for vga_ports: directed OUT/IN cycles, palette RAM model, scoreboarded reads and DAC writes.
// Reads and dac_we pulses are checked by monitors against queues filled by the stimulus.
// Strobes are spaced by three idle cycles, as the CPU bus guarantees.
module tb_vga_ports;

  logic        clock_25 = 1'b0;
  logic        reset_n;
  logic [15:0] io_address;
  logic        io_write;
  logic        io_read;
  logic [7:0]  io_data_in;
  logic [7:0]  io_data_out;
  logic        vretrace;
  logic        display_off;
  logic [10:0] cursor;
  logic [5:0]  cursor_shape_lo;
  logic [4:0]  cursor_shape_hi;
  logic [1:0]  videomode;
  logic [7:0]  dac_address;
  logic        dac_we;
  logic [31:0] dac_wdata;
  logic [31:0] dac_rdata;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  rd_q[$];
  string       rd_name_q[$];
  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  logic [31:0] ram [256];
  logic        ram_seeded = 1'b0;

  always #20 clock_25 = ~clock_25;

  vga_ports dut (
    .clock_25        (clock_25),
    .reset_n         (reset_n),
    .io_address      (io_address),
    .io_write        (io_write),
    .io_read         (io_read),
    .io_data_in      (io_data_in),
    .io_data_out     (io_data_out),
    .vretrace        (vretrace),
    .display_off     (display_off),
    .cursor          (cursor),
    .cursor_shape_lo (cursor_shape_lo),
    .cursor_shape_hi (cursor_shape_hi),
    .videomode       (videomode),
    .dac_address     (dac_address),
    .dac_we          (dac_we),
    .dac_wdata       (dac_wdata),
    .dac_rdata       (dac_rdata)
  );

  // Palette RAM model: synchronous read, one cycle after the address.
  always @(posedge clock_25) begin
    if (!ram_seeded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
      ram[8'h10] <= 32'h00FC8004;
      ram_seeded <= 1'b1;
    end else if (dac_we) begin
      ram[dac_address] <= dac_wdata;
    end
    dac_rdata <= ram[dac_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Read monitor: every read-only strobe must match the next queued expectation.
  always @(posedge clock_25) begin
    if (io_read && !io_write) begin
      @(negedge clock_25);
      if (rd_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_read: got %h, expected no read", io_data_out);
      end else begin
        check(rd_name_q.pop_front(), {24'd0, io_data_out}, {24'd0, rd_q.pop_front()});
      end
    end
  end

  // Write monitor: every dac_we pulse must match the next queued palette write.
  always @(negedge clock_25) begin
    if (dac_we) begin
      if (wq_addr.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_dac_we: got addr %h data %h, expected none", dac_address, dac_wdata);
      end else begin
        check("dac_we_addr", {24'd0, dac_address}, {24'd0, wq_addr.pop_front()});
        check("dac_we_data", dac_wdata, wq_data.pop_front());
      end
    end
  end

  task automatic io_out(input logic [15:0] a, input logic [7:0] d);
    @(posedge clock_25); #1;
    io_address = a;
    io_data_in = d;
    io_write   = 1'b1;
    @(posedge clock_25); #1;
    io_write = 1'b0;
    repeat (3) @(posedge clock_25);
  endtask

  task automatic io_in(input logic [15:0] a, input logic [7:0] exp, input string name);
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clock_25); #1;
    io_address = a;
    io_read    = 1'b1;
    @(posedge clock_25); #1;
    io_read = 1'b0;
    repeat (3) @(posedge clock_25);
  endtask

  initial begin
    reset_n     = 1'b0;
    io_address  = 16'd0;
    io_write    = 1'b0;
    io_read     = 1'b0;
    io_data_in  = 8'd0;
    vretrace    = 1'b0;
    display_off = 1'b0;
    repeat (3) @(posedge clock_25);
    #1 reset_n = 1'b1;
    @(negedge clock_25);
    check("rst_cursor",   {21'd0, cursor},          32'd0);
    check("rst_shape_lo", {26'd0, cursor_shape_lo}, 32'd14);
    check("rst_shape_hi", {27'd0, cursor_shape_hi}, 32'd15);
    check("rst_mode",     {30'd0, videomode},       32'd0);
    check("rst_data_out", {24'd0, io_data_out},     32'hFF);
    check("rst_dac_we",   {31'd0, dac_we},          32'd0);
    check("rst_dac_addr", {24'd0, dac_address},     32'd0);
    check("rst_dac_wdata", dac_wdata,               32'd0);

    // CRTC: cursor shape readback and cursor position.
    io_out(16'h03D4, 8'h0A);
    io_in (16'h03D4, 8'h0A, "crtc_index_rd");
    io_in (16'h03D5, 8'h0E, "shape_lo_rst_rd");
    io_out(16'h03D4, 8'h0E);
    io_out(16'h03D5, 8'h07);
    io_out(16'h03D4, 8'h0F);
    io_out(16'h03D5, 8'hCF);
    @(negedge clock_25);
    check("cursor_7cf", {21'd0, cursor}, 32'h7CF);
    io_in (16'h03D5, 8'hCF, "cursor_lo_rd");
    io_out(16'h03D4, 8'h0E);
    io_in (16'h03D5, 8'h07, "cursor_hi_rd");
    io_out(16'h03D4, 8'h0B);
    io_out(16'h03D5, 8'hFF);
    io_out(16'h03D4, 8'h0A);
    io_out(16'h03D5, 8'h25);
    @(negedge clock_25);
    check("shape_hi_1f", {27'd0, cursor_shape_hi}, 32'h1F);
    check("shape_lo_25", {26'd0, cursor_shape_lo}, 32'h25);
    io_out(16'h03D4, 8'h05);
    io_out(16'h03D5, 8'h77);
    io_in (16'h03D5, 8'h00, "crtc_undef_rd");
    @(negedge clock_25);
    check("cursor_kept", {21'd0, cursor}, 32'h7CF);

    // Mode register, status port, undecoded and fixed ports.
    io_out(16'h03D8, 8'h03);
    @(negedge clock_25);
    check("mode_3", {30'd0, videomode}, 32'd3);
    io_in (16'h03D8, 8'h03, "mode_rd");
    io_out(16'h03D8, 8'hFE);
    @(negedge clock_25);
    check("mode_2", {30'd0, videomode}, 32'd2);
    vretrace = 1'b1;
    display_off = 1'b1;
    io_in (16'h03DA, 8'h09, "status_11");
    display_off = 1'b0;
    io_in (16'h03DA, 8'h08, "status_10");
    io_in (16'h03C0, 8'hFF, "undecoded_rd");
    io_in (16'h03C7, 8'h03, "ridx_port_rd");

    // Palette write triple at index FF, index wraps to 0.
    io_out(16'h03C8, 8'hFF);
    wq_addr.push_back(8'hFF);
    wq_data.push_back(32'h00FF0055);
    io_out(16'h03C9, 8'h3F);
    io_out(16'h03C9, 8'h00);
    io_out(16'h03C9, 8'h15);
    io_in (16'h03C8, 8'h00, "widx_wrap");

    // Palette read of entry 10, next fetch addresses 11.
    io_out(16'h03C7, 8'h10);
    io_in (16'h03C9, 8'h3F, "pal_rd_r");
    io_in (16'h03C9, 8'h20, "pal_rd_g");
    io_in (16'h03C9, 8'h01, "pal_rd_b");
    @(negedge clock_25);
    check("next_fetch_addr", {24'd0, dac_address}, 32'h11);

    // Simultaneous write and read: write lands, read data forced to FF.
    @(posedge clock_25); #1;
    io_address = 16'h03D8;
    io_data_in = 8'h01;
    io_write   = 1'b1;
    io_read    = 1'b1;
    @(posedge clock_25); #1;
    io_write = 1'b0;
    io_read  = 1'b0;
    @(negedge clock_25);
    check("wr_rd_data_out", {24'd0, io_data_out}, 32'hFF);
    check("wr_rd_mode",     {30'd0, videomode},   32'd1);

    // Reset mid-triple: no write; restart counts phases from zero.
    io_out(16'h03C8, 8'h20);
    io_out(16'h03C9, 8'h01);
    io_out(16'h03C9, 8'h02);
    @(posedge clock_25); #1;
    reset_n = 1'b0;
    @(negedge clock_25);
    check("mid_reset_we", {31'd0, dac_we}, 32'd0);
    @(posedge clock_25); #1;
    reset_n = 1'b1;
    io_out(16'h03C9, 8'h0A);
    wq_addr.push_back(8'h00);
    wq_data.push_back(32'h00282C30);
    io_out(16'h03C9, 8'h0B);
    io_out(16'h03C9, 8'h0C);

    repeat (5) @(posedge clock_25);
    check("pending_reads",  rd_q.size(),    32'd0);
    check("pending_writes", wq_addr.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
